// File: rtl/riscv_ctrl_defs.sv
// Shared RISC-V control definitions for the decode and execute control units.
// Holds opcode[6:2] class codes, control-field encodings, the NOP
// instruction, and the packed control/tag types.
// No ports (package).
package riscv_ctrl_defs;

   // Inst[6:2] class codes
   localparam logic [4:0] opcode_R     = 5'b01100;
   localparam logic [4:0] opcode_I     = 5'b00100;
   localparam logic [4:0] opcode_L     = 5'b00000;
   localparam logic [4:0] opcode_S     = 5'b01000;
   localparam logic [4:0] opcode_B     = 5'b11000;
   localparam logic [4:0] opcode_JALR  = 5'b11001;
   localparam logic [4:0] opcode_JAL   = 5'b11011;
   localparam logic [4:0] opcode_AUIPC = 5'b00101;
   localparam logic [4:0] opcode_LUI   = 5'b01101;
   localparam logic [4:0] opcode_CSR   = 5'b11100;

   // Store width
   localparam logic [1:0] MEM_NONE = 2'b00;
   localparam logic [1:0] MEM_SW   = 2'b01;
   localparam logic [1:0] MEM_SH   = 2'b10;
   localparam logic [1:0] MEM_SB   = 2'b11;

   // Load extract/extend
   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_H  = 3'b001;
   localparam logic [2:0] LD_B  = 3'b010;
   localparam logic [2:0] LD_HU = 3'b011;
   localparam logic [2:0] LD_BU = 3'b100;

   // Writeback source
   localparam logic [1:0] WB_MEM = 2'b00;
   localparam logic [1:0] WB_ALU = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;

   // Operand forwarding source
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_EX = 2'b01;
   localparam logic [1:0] FWD_WB = 2'b10;

   // ADDI x0,x0,0
   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [1:0] memrw;
      logic       regwen;
      logic [2:0] ldsel;
      logic [1:0] wbsel;
      logic       csrsel;
   } ctrl_t;

   // Producer tag carried alongside an instruction down the pipe
   typedef struct packed {
      logic [4:0] rd;
      logic       wen;
      logic       ld;
   } tag_t;

endpackage

// File: rtl/decode_ctrl_comb.sv
// Purely combinational instruction -> control-field decoder.
// Ports:
//   i_inst     instruction word
//   o_ctrl     decoded control fields (MemRW/RegWen/LdSel/WBSel/CSRSel)
//   o_rd/o_rs1/o_rs2  register fields
//   o_use_rs1/o_use_rs2  instruction actually reads that source
//   o_is_load  instruction is a load
// Unknown opcodes decode to all-zero controls with no source use.
module decode_ctrl_comb
   import riscv_ctrl_defs::*;
(
   input  logic [31:0] i_inst,
   output ctrl_t       o_ctrl,
   output logic [4:0]  o_rd,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic        o_use_rs1,
   output logic        o_use_rs2,
   output logic        o_is_load
);

   logic [4:0] w_op;
   logic [2:0] w_f3;
   logic       w_unused_bits;

   assign w_op  = i_inst[6:2];
   assign w_f3  = i_inst[14:12];
   assign o_rd  = i_inst[11:7];
   assign o_rs1 = i_inst[19:15];
   assign o_rs2 = i_inst[24:20];
   assign w_unused_bits = ^{i_inst[31:25], i_inst[1:0]};

   always_comb begin
      o_ctrl    = '0;
      o_use_rs1 = 1'b0;
      o_use_rs2 = 1'b0;
      o_is_load = 1'b0;
      case (w_op)
         opcode_R: begin
            o_ctrl.regwen = 1'b1;
            o_ctrl.wbsel  = WB_ALU;
            o_use_rs1     = 1'b1;
            o_use_rs2     = 1'b1;
         end
         opcode_I: begin
            o_ctrl.regwen = 1'b1;
            o_ctrl.wbsel  = WB_ALU;
            o_use_rs1     = 1'b1;
         end
         opcode_L: begin
            o_ctrl.regwen = 1'b1;
            o_ctrl.wbsel  = WB_MEM;
            o_use_rs1     = 1'b1;
            o_is_load     = 1'b1;
            case (w_f3)
               3'b000:  o_ctrl.ldsel = LD_B;
               3'b001:  o_ctrl.ldsel = LD_H;
               3'b100:  o_ctrl.ldsel = LD_BU;
               3'b101:  o_ctrl.ldsel = LD_HU;
               default: o_ctrl.ldsel = LD_W;
            endcase
         end
         opcode_S: begin
            o_use_rs1 = 1'b1;
            o_use_rs2 = 1'b1;
            case (w_f3)
               3'b000:  o_ctrl.memrw = MEM_SB;
               3'b001:  o_ctrl.memrw = MEM_SH;
               3'b010:  o_ctrl.memrw = MEM_SW;
               default: o_ctrl.memrw = MEM_NONE;
            endcase
         end
         opcode_B: begin
            o_use_rs1 = 1'b1;
            o_use_rs2 = 1'b1;
         end
         opcode_JALR: begin
            o_ctrl.regwen = 1'b1;
            o_ctrl.wbsel  = WB_PC4;
            o_use_rs1     = 1'b1;
         end
         opcode_JAL: begin
            o_ctrl.regwen = 1'b1;
            o_ctrl.wbsel  = WB_PC4;
         end
         opcode_AUIPC, opcode_LUI: begin
            o_ctrl.regwen = 1'b1;
            o_ctrl.wbsel  = WB_ALU;
         end
         opcode_CSR: begin
            // csrrw (001) / csrrwi (101) write the CSR; register forms
            // (001/010/011) read rs1, immediate forms carry uimm there.
            o_ctrl.csrsel = (w_f3[1:0] == 2'b01);
            o_use_rs1     = ~w_f3[2] & (w_f3[1:0] != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_unit_decode.sv
// Decode-stage control unit: registers the fetched instruction and its
// decoded controls into the decode/EX register, detects RAW / load-use
// hazards against the two older producers, inserts bubbles, stalls fetch
// and selects operand forwarding.
// Optional build macro: CONTROL_DECODE_FWD_EN (forwarding enabled; only
// load-use stalls, one bubble). Undefined: any RAW against the two older
// producers stalls, Fwd selects tied to 00.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   Inst_IF            fetched instruction
//   Flush              EX control-hazard window; discards Inst_IF
//   Stall_IF           (comb) fetch must re-present Inst_IF
//   Inst_decode_reg    registered instruction to EX
//   Hold_decode_reg    decode register holds a bubble (STALL state)
//   *_decode_reg       registered control fields
//   FwdA/FwdB_decode_reg  rs1/rs2 forwarding select
//   Stall_count        saturating bubble counter
module control_unit_decode #(
   parameter logic [31:0] NOP_INST    = riscv_ctrl_defs::NOP_INST,
   parameter int          STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            Inst_IF,
   input  logic                   Flush,
   output logic                   Stall_IF,
   output logic [31:0]            Inst_decode_reg,
   output logic                   Hold_decode_reg,
   output logic [1:0]             MemRW_decode_reg,
   output logic                   RegWen_decode_reg,
   output logic [2:0]             LdSel_decode_reg,
   output logic [1:0]             WBSel_decode_reg,
   output logic                   CSRSel_decode_reg,
   output logic [1:0]             FwdA_decode_reg,
   output logic [1:0]             FwdB_decode_reg,
   output logic [STALL_CNT_W-1:0] Stall_count
);
   import riscv_ctrl_defs::*;

   typedef enum logic {ST_RUN = 1'b0, ST_STALL = 1'b1} state_t;

   ctrl_t      w_ctrl;
   logic [4:0] w_rd, w_rs1, w_rs2;
   logic       w_use_rs1, w_use_rs2, w_is_load;

   decode_ctrl_comb u_dec (
      .i_inst    (Inst_IF),
      .o_ctrl    (w_ctrl),
      .o_rd      (w_rd),
      .o_rs1     (w_rs1),
      .o_rs2     (w_rs2),
      .o_use_rs1 (w_use_rs1),
      .o_use_rs2 (w_use_rs2),
      .o_is_load (w_is_load)
   );

   state_t                 r_state;
   logic [31:0]            r_inst;
   ctrl_t                  r_ctrl;
   logic [1:0]             r_fwda, r_fwdb;
   tag_t                   r_tag_d, r_tag_x;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   // Source matches against the decode-register (d) and EX (x) producers.
   // A zero source never matches, so rd=x0 producers are harmless.
   logic w_m1d, w_m2d, w_m1x, w_m2x;
   assign w_m1d = w_use_rs1 & (w_rs1 != 5'd0) & r_tag_d.wen & (r_tag_d.rd == w_rs1);
   assign w_m2d = w_use_rs2 & (w_rs2 != 5'd0) & r_tag_d.wen & (r_tag_d.rd == w_rs2);
   assign w_m1x = w_use_rs1 & (w_rs1 != 5'd0) & r_tag_x.wen & (r_tag_x.rd == w_rs1);
   assign w_m2x = w_use_rs2 & (w_rs2 != 5'd0) & r_tag_x.wen & (r_tag_x.rd == w_rs2);

   logic       w_hazard;
   logic [1:0] w_fwda, w_fwdb;

`ifdef CONTROL_DECODE_FWD_EN
   // Only a load directly ahead cannot be bypassed; after one bubble the
   // load sits in tag_x and its data comes from WB.
   assign w_hazard = r_tag_d.ld & (w_m1d | w_m2d);
   assign w_fwda   = (w_m1d & ~r_tag_d.ld) ? FWD_EX : (w_m1x ? FWD_WB : FWD_RF);
   assign w_fwdb   = (w_m2d & ~r_tag_d.ld) ? FWD_EX : (w_m2x ? FWD_WB : FWD_RF);
`else
   // No bypass: wait until both older producers have drained.
   assign w_hazard = w_m1d | w_m2d | w_m1x | w_m2x;
   assign w_fwda   = FWD_RF;
   assign w_fwdb   = FWD_RF;
`endif

   assign Stall_IF = ~rst & ~Flush & w_hazard;

   logic w_unused_tag;
   assign w_unused_tag = r_tag_x.ld ^ r_tag_d.ld;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_RUN;
         r_inst      <= NOP_INST;
         r_ctrl      <= '0;
         r_fwda      <= FWD_RF;
         r_fwdb      <= FWD_RF;
         r_tag_d     <= '0;
         r_tag_x     <= '0;
         r_stall_cnt <= '0;
      end else if (Flush) begin
         // Wrong-path instructions: neither the one entering nor the one
         // leaving decode may act as a producer.
         r_state <= ST_RUN;
         r_inst  <= NOP_INST;
         r_ctrl  <= '0;
         r_fwda  <= FWD_RF;
         r_fwdb  <= FWD_RF;
         r_tag_d <= '0;
         r_tag_x <= '0;
      end else if (w_hazard) begin
         r_state <= ST_STALL;
         r_inst  <= NOP_INST;
         r_ctrl  <= '0;
         r_fwda  <= FWD_RF;
         r_fwdb  <= FWD_RF;
         r_tag_x <= r_tag_d;
         r_tag_d <= '0;
         if (~&r_stall_cnt)
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end else begin
         r_state <= ST_RUN;
         r_inst  <= Inst_IF;
         r_ctrl  <= w_ctrl;
         r_fwda  <= w_fwda;
         r_fwdb  <= w_fwdb;
         r_tag_x <= r_tag_d;
         r_tag_d <= {w_rd, w_ctrl.regwen, w_is_load};
      end
   end

   assign Inst_decode_reg   = r_inst;
   assign Hold_decode_reg   = (r_state == ST_STALL);
   assign MemRW_decode_reg  = r_ctrl.memrw;
   assign RegWen_decode_reg = r_ctrl.regwen;
   assign LdSel_decode_reg  = r_ctrl.ldsel;
   assign WBSel_decode_reg  = r_ctrl.wbsel;
   assign CSRSel_decode_reg = r_ctrl.csrsel;
   assign FwdA_decode_reg   = r_fwda;
   assign FwdB_decode_reg   = r_fwdb;
   assign Stall_count       = r_stall_cnt;

endmodule

// File: doc/control_unit_decode.md
Name: control_unit_decode

Overview:
- Decode-stage control unit, directly upstream of the execute-stage control unit.
- Registers the fetched instruction and its decoded control fields into the decode/EX pipeline register. Produces the `*_decode_reg` fields, `Inst_decode_reg` and `Hold_decode_reg` that the execute stage consumes.
- Detects load-use and RAW hazards, inserts bubbles, stalls fetch, and drives rs1/rs2 forwarding selects.

Parameters:
- NOP_INST, 32'h0000_0013, instruction loaded into the decode register on reset/bubble/flush.
- STALL_CNT_W, 32, width of the saturating stall performance counter.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- Inst_IF  input  32  instruction from fetch (valid every cycle)
- Flush  input  1  EX control-hazard window active (OR of EX hazard pipeline)
- Stall_IF  output  1  combinational; fetch must re-present the same Inst_IF next cycle
- Inst_decode_reg  output  32  registered instruction handed to EX
- Hold_decode_reg  output  1  registered; decode register holds a bubble
- MemRW_decode_reg  output  2  00 none, 01 SW, 10 SH, 11 SB
- RegWen_decode_reg  output  1  rd write enable
- LdSel_decode_reg  output  3  000 LW, 001 LH, 010 LB, 011 LHU, 100 LBU
- WBSel_decode_reg  output  2  00 mem, 01 ALU, 10 PC+4
- CSRSel_decode_reg  output  1  csrw/csrwi
- FwdA_decode_reg, FwdB_decode_reg  output  2 each  00 regfile, 01 EX result, 10 WB data
- Stall_count  output  STALL_CNT_W  saturating count of bubble cycles

Behaviour:
- Latency: 1 cycle from Inst_IF to all `*_decode_reg` outputs.
- Reset:
  - Inst_decode_reg=NOP_INST; all control outputs 0.
  - Hold_decode_reg=0; Stall_count=0.
  - Tag pipeline cleared.
- Decode uses opcode = Inst[6:2], funct3 = Inst[14:12]. Classes: R, I, L, S, B, JALR, JAL, AUIPC, LUI, CSR. Unknown opcode decodes as a NOP, with all control fields 0.
- Source use:
  - rs1 is used by R, I, L, S, B, JALR and CSR-register forms.
  - rs2 is used by R, S and B.
  - Register x0 is never a hazard source.
- Tag pipeline: tag_d = {rd, RegWen, is_load} of the decode register; tag_x = tag_d delayed by 1 cycle. Bubbles carry RegWen=0.
- Hazard (with forwarding): Inst_IF sources match tag_d.rd, tag_d.RegWen=1, tag_d.is_load=1 -> load-use.
- Next-state priority, highest first:
  1. rst.
  2. Flush=1: load NOP_INST with Hold_decode_reg=0. Stall_IF=0; the instruction is discarded. Tags are cleared to RegWen=0.
  3. Hazard: Stall_IF=1. Load a bubble: Inst=NOP_INST, Hold_decode_reg=1, all controls 0. Stall_count increments unless saturated.
  4. Otherwise: load Inst_IF and its decoded fields with Hold_decode_reg=0.
- States: RUN / STALL. The registered state is Hold_decode_reg.
  - STALL->RUN on the next non-hazard cycle.
  - STALL->STALL is allowed only without forwarding (2-deep dependency).
- Forwarding selects, computed against the tags at load time:
  - EX match (tag_d, non-load) -> 01.
  - Else WB match (tag_x) -> 10.
  - Else 00.
  - EX has priority over WB.
- rd=x0 with RegWen=1 never forwards and never stalls.
- Stall_count saturates at all-ones and is not cleared by Flush.

Optional Feature:
- CONTROL_DECODE_FWD_EN
- Defined: forwarding as above; maximum 1 bubble per load-use.
- Undefined:
  - FwdA/FwdB are tied to 00.
  - Any RAW match with tag_d or tag_x (any RegWen=1 producer) stalls.
  - Up to 2 consecutive bubbles.

Decomposition:
- Shared package/header (`riscv_ctrl_defs`) holds:
  - opcode localparams (opcode_R..opcode_CSR);
  - MemRW, LdSel, WBSel and Fwd encodings;
  - NOP_INST.
- The EX control unit uses the same header.
- One sub-module, `decode_ctrl_comb`: purely combinational instruction->control-field decoder. The parent holds the registers, tags, hazard FSM and counter.

Test Plan:
- Reset, then `ADDI x1,x0,5` (0x00500093) -> 1 cycle later: Inst_decode_reg=0x00500093, RegWen=1, WBSel=01, Hold=0.
- `LW x2,0(x1)` then `ADD x3,x2,x2`:
  - With FWD_EN: Stall_IF=1 for 1 cycle; Hold_decode_reg=1 for 1 cycle; then ADD issues with FwdA=FwdB=10; Stall_count=1.
  - Without FWD_EN: ADD is held for 2 cycles.
- `ADDI x1,x0,1` then `ADD x4,x1,x0`:
  - With FWD_EN: no stall; FwdA=01, FwdB=00.
  - Without FWD_EN: 2 bubbles.
- Load to x0 followed by a user of x0 -> no stall; Fwd=00.
- Flush=1 while a load-use hazard is pending -> Stall_IF=0, Hold_decode_reg=0, Inst_decode_reg=NOP_INST, Stall_count unchanged.
- rst asserted during STALL -> next cycle: all outputs at reset values; Stall_count=0.
